// File: rtl/im_prefetch_pkg.sv
// rtl/im_prefetch_pkg.sv - shared fetch-path constants and PC helpers
package im_prefetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_ALIGN = 4;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t ALIGN_MASK       = ~word_t'(INSTR_ALIGN - 1);

  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(INSTR_ALIGN);
  endfunction

  function automatic word_t pc_align(input word_t a);
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/im_prefetch_if.sv
// rtl/im_prefetch_if.sv - CPU fetch port and instruction memory port bundle
interface im_prefetch_if;
  import im_prefetch_pkg::*;

  logic  IM_enable;
  word_t IM_address;
  word_t IM_out;
  logic  IM_valid;
  logic  mem_req;
  word_t mem_addr;
  logic  mem_gnt;
  logic  mem_rvalid;
  word_t mem_rdata;

  modport slave (
    input  IM_enable, IM_address, mem_gnt, mem_rvalid, mem_rdata,
    output IM_out, IM_valid, mem_req, mem_addr
  );

  modport master (
    output IM_enable, IM_address, mem_gnt, mem_rvalid, mem_rdata,
    input  IM_out, IM_valid, mem_req, mem_addr
  );

endinterface

// File: rtl/im_prefetch_ifq_fifo.sv
// rtl/im_prefetch_ifq_fifo.sv - DEPTH x word instruction FIFO, flush beats push
module ifq_fifo
  import im_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  word_t         i_din,
  output word_t         o_dout,
  output logic [CW-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  word_t         r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_push && !i_pop && !i_flush && r_count == CW'(DEPTH)));

  a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_pop && r_count == '0));

endmodule

// File: rtl/im_prefetch.sv
// rtl/im_prefetch.sv - sequential instruction prefetch queue with redirect flush
module im_prefetch
  import im_prefetch_pkg::*;
#(
  parameter int    DEPTH           = 4,
  parameter int    MAX_OUTSTANDING = 2,
  parameter word_t RESET_PC        = RESET_PC_DEFAULT
) (
  input logic         clk,
  input logic         rst,
  im_prefetch_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  word_t         r_fetch_pc;
  word_t         r_cons_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  word_t         w_dout;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occupancy;
  logic          w_match;
  logic          w_redirect;
  logic          w_hit;
  logic          w_issue;
  logic          w_grant;
  logic          w_rsp;
  logic          w_push;

  assign w_match     = (pc_align(bus.IM_address) == r_cons_pc);
  assign w_redirect  = bus.IM_enable & ~w_match;
  assign w_hit       = bus.IM_enable & w_match & (w_count != '0);
  assign w_occupancy = {1'b0, w_count} + {1'b0, r_outstanding};

  // Reserving FIFO space at issue time is what makes overflow impossible.
  assign w_issue = rst & ~w_redirect
                 & (w_occupancy < (CW + 1)'(DEPTH))
                 & (r_outstanding < CW'(MAX_OUTSTANDING));
  assign w_grant = w_issue & bus.mem_gnt;

  // Responses with nothing in flight are leftovers from before a reset.
  assign w_rsp  = bus.mem_rvalid & (r_outstanding != '0);
  assign w_push = w_rsp & ~w_redirect & (r_drop_cnt == '0);

  assign bus.mem_req  = w_issue;
  assign bus.mem_addr = r_fetch_pc;
  assign bus.IM_valid = w_hit;
  assign bus.IM_out   = w_hit ? w_dout : '0;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_hit),
    .i_flush (w_redirect),
    .i_din   (bus.mem_rdata),
    .o_dout  (w_dout),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= pc_align(RESET_PC);
      r_cons_pc     <= pc_align(RESET_PC);
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_redirect) begin
        r_fetch_pc <= pc_align(bus.IM_address);
        r_cons_pc  <= pc_align(bus.IM_address);
        // Everything still in flight belongs to the old stream.
        r_drop_cnt <= r_outstanding - CW'(w_rsp);
      end else begin
        if (w_grant) r_fetch_pc <= pc_inc(r_fetch_pc);
        if (w_hit)   r_cons_pc  <= pc_inc(r_cons_pc);
        if (w_rsp && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_rsp);
    end
  end

  a_outstanding_cap: assert property (@(posedge clk) disable iff (!rst)
    r_outstanding <= CW'(MAX_OUTSTANDING));

  a_occupancy_cap: assert property (@(posedge clk) disable iff (!rst)
    w_occupancy <= (CW + 1)'(DEPTH));

endmodule

// File: tb/tb_im_prefetch.sv
// tb/tb_im_prefetch.sv - directed vector table plus corner sequences for im_prefetch
module tb_im_prefetch;
  import im_prefetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  im_prefetch_if bus();

  im_prefetch #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        clrq;
    int          lat;
    logic        en;
    logic [31:0] addr;
    logic        gnt;
    logic        req;
    logic [31:0] maddr;
    logic        valid;
    logic [31:0] oaddr;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] a;
  } rsp_t;

  rsp_t q[$];
  vec_t tbl[$];
  int   cyc, lat_cur, last_due;
  int   checks, failures;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t row(input int lat, input logic en, input logic [31:0] addr,
                               input logic gnt, input logic req, input logic [31:0] maddr,
                               input logic valid, input logic [31:0] oaddr);
    vec_t v;
    v.rst = 1'b1; v.clrq = 1'b0; v.lat = lat; v.en = en; v.addr = addr; v.gnt = gnt;
    v.req = req; v.maddr = maddr; v.valid = valid; v.oaddr = oaddr;
    return v;
  endfunction

  function automatic vec_t rrow(input logic clrq);
    vec_t v;
    v = row(1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    v.rst  = 1'b0;
    v.clrq = clrq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [31:0] a, input logic g);
    rst            = r;
    bus.IM_enable  = en;
    bus.IM_address = a;
    bus.mem_gnt    = g;
    if (q.size() > 0 && q[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_word(q[0].a);
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
    #1;
  endtask

  task automatic advance();
    int   d;
    rsp_t e;
    if (bus.mem_rvalid) void'(q.pop_front());
    if (rst && bus.mem_req && bus.mem_gnt) begin
      d = cyc + lat_cur;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      e.due = d;
      e.a   = bus.mem_addr;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    if (v.clrq) begin
      q.delete();
      last_due = 0;
    end
    lat_cur = v.lat;
    drive(v.rst, v.en, v.addr, v.gnt);
    chk($sformatf("vec%0d.mem_req", idx), 32'(bus.mem_req), 32'(v.req));
    if (v.req) chk($sformatf("vec%0d.mem_addr", idx), bus.mem_addr, v.maddr);
    chk($sformatf("vec%0d.IM_valid", idx), 32'(bus.IM_valid), 32'(v.valid));
    if (v.valid) chk($sformatf("vec%0d.IM_out", idx), bus.IM_out, mem_word(v.oaddr));
    else if (!v.rst) chk($sformatf("vec%0d.IM_out_rst", idx), bus.IM_out, 32'h0);
    advance();
  endtask

  initial begin
    logic [31:0] cpu_pc, prev_addr;
    logic        prev_pend, jump, en, hit;
    int          consumed;

    checks = 0; failures = 0; cyc = 0; lat_cur = 1; last_due = 0;
    bus.IM_enable = 1'b0; bus.IM_address = '0; bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    // zero-wait streaming from reset
    tbl.push_back(rrow(1)); tbl.push_back(rrow(0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h0,  0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h4,  0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h8,  1, 32'h0));
    tbl.push_back(row(1, 1, 32'h4, 1, 1, 32'hC,  1, 32'h4));
    tbl.push_back(row(1, 1, 32'h8, 1, 1, 32'h10, 1, 32'h8));
    // redirect near the top of the address space, PC wraps to 0
    tbl.push_back(rrow(1)); tbl.push_back(rrow(0));
    tbl.push_back(row(1, 1, 32'hFFFF_FFF8, 1, 0, 32'h0,         0, 32'h0));
    tbl.push_back(row(1, 1, 32'hFFFF_FFF8, 1, 1, 32'hFFFF_FFF8, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'hFFFF_FFF8, 1, 1, 32'hFFFF_FFFC, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'hFFFF_FFF8, 1, 1, 32'h0,         1, 32'hFFFF_FFF8));
    tbl.push_back(row(1, 1, 32'hFFFF_FFFC, 1, 1, 32'h4,         1, 32'hFFFF_FFFC));
    tbl.push_back(row(1, 1, 32'h0,         1, 1, 32'h8,         1, 32'h0));
    // CPU idle: fill to the occupancy cap, one pop reopens a slot
    tbl.push_back(rrow(1)); tbl.push_back(rrow(0));
    tbl.push_back(row(1, 0, 32'h0, 1, 1, 32'h0,  0, 32'h0));
    tbl.push_back(row(1, 0, 32'h0, 1, 1, 32'h4,  0, 32'h0));
    tbl.push_back(row(1, 0, 32'h0, 1, 1, 32'h8,  0, 32'h0));
    tbl.push_back(row(1, 0, 32'h0, 1, 1, 32'hC,  0, 32'h0));
    for (int i = 0; i < 3; i++) tbl.push_back(row(1, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 0, 32'h0,  1, 32'h0));
    tbl.push_back(row(1, 0, 32'h0, 1, 1, 32'h10, 0, 32'h0));
    tbl.push_back(row(1, 0, 32'h0, 1, 0, 32'h0,  0, 32'h0));
    tbl.push_back(row(1, 0, 32'h0, 1, 0, 32'h0,  0, 32'h0));
    // redirect to 0x40 with two requests in flight, latency 3
    tbl.push_back(rrow(1)); tbl.push_back(rrow(0));
    tbl.push_back(row(3, 1, 32'h0,  1, 1, 32'h0,  0, 32'h0));
    tbl.push_back(row(3, 1, 32'h0,  1, 1, 32'h4,  0, 32'h0));
    tbl.push_back(row(3, 1, 32'h40, 1, 0, 32'h0,  0, 32'h0));
    tbl.push_back(row(3, 1, 32'h40, 1, 0, 32'h0,  0, 32'h0));
    tbl.push_back(row(3, 1, 32'h40, 1, 1, 32'h40, 0, 32'h0));
    tbl.push_back(row(3, 1, 32'h40, 1, 1, 32'h44, 0, 32'h0));
    tbl.push_back(row(3, 1, 32'h40, 1, 0, 32'h0,  0, 32'h0));
    tbl.push_back(row(3, 1, 32'h40, 1, 0, 32'h0,  0, 32'h0));
    tbl.push_back(row(3, 1, 32'h40, 1, 1, 32'h48, 1, 32'h40));
    tbl.push_back(row(3, 1, 32'h44, 1, 1, 32'h4C, 1, 32'h44));
    // grant withheld for five cycles
    tbl.push_back(rrow(1)); tbl.push_back(rrow(0));
    for (int i = 0; i < 5; i++) tbl.push_back(row(1, 1, 32'h0, 0, 1, 32'h0, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h0, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h4, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h8, 1, 32'h0));
    // reset with two in flight; their late responses must be ignored
    tbl.push_back(rrow(1)); tbl.push_back(rrow(0));
    tbl.push_back(row(8, 1, 32'h0, 1, 1, 32'h0, 0, 32'h0));
    tbl.push_back(row(8, 1, 32'h0, 1, 1, 32'h4, 0, 32'h0));
    tbl.push_back(rrow(0)); tbl.push_back(rrow(0));
    for (int i = 0; i < 6; i++) tbl.push_back(row(8, 1, 32'h0, 0, 1, 32'h0, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 0, 1, 32'h0, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h0, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h4, 0, 32'h0));
    tbl.push_back(row(1, 1, 32'h0, 1, 1, 32'h8, 1, 32'h0));

    @(negedge clk);
    foreach (tbl[i]) run_vec(tbl[i], i);

    // reset asserted between clock edges must clear state immediately
    run_vec(rrow(1), 900); run_vec(rrow(0), 901);
    run_vec(row(1, 1, 32'h0, 1, 1, 32'h0, 0, 32'h0), 902);
    run_vec(row(1, 1, 32'h0, 1, 1, 32'h4, 0, 32'h0), 903);
    drive(1'b1, 1'b1, 32'h0, 1'b1);
    chk("async.valid_before", 32'(bus.IM_valid), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async.valid_after", 32'(bus.IM_valid), 32'h0);
    chk("async.req_after", 32'(bus.mem_req), 32'h0);
    q.delete(); last_due = 0;
    @(posedge clk); @(negedge clk); cyc++;
    run_vec(row(1, 1, 32'h0, 1, 1, 32'h0, 0, 32'h0), 904);

    // random memory timing and branches against a word-per-address scoreboard
    run_vec(rrow(1), 910); run_vec(rrow(0), 911);
    cpu_pc = 32'h0; prev_pend = 1'b0; prev_addr = '0; consumed = 0;
    for (int i = 0; i < 600; i++) begin
      jump = ($urandom_range(0, 19) == 0);
      en   = jump | ($urandom_range(0, 7) != 0);
      if (jump) cpu_pc = $urandom() & 32'hFFFF_FFFC;
      lat_cur = $urandom_range(1, 3);
      drive(1'b1, en, cpu_pc, ($urandom_range(0, 3) != 0));
      if (prev_pend && !jump) begin
        chk("rnd.req_hold", 32'(bus.mem_req), 32'h1);
        chk("rnd.addr_hold", bus.mem_addr, prev_addr);
      end
      hit = bus.IM_valid;
      if (hit) begin
        chk("rnd.data", bus.IM_out, mem_word(cpu_pc));
        consumed++;
      end
      prev_pend = bus.mem_req & ~bus.mem_gnt;
      prev_addr = bus.mem_addr;
      advance();
      if (hit) cpu_pc = cpu_pc + 32'd4;
    end
    chk("rnd.progress", 32'(consumed >= 60), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
